// File: rtl/dec_6_to_64.sv
// -----------------------------------------------------------------------------
// dec_6_to_64 -- registered 6-to-64 wordline decoder for the SRAM row path.
//
// The 6-bit row address is split into three 2-bit groups. Each group is
// predecoded to 4 one-hot lines. Each of the 64 wordlines is then a 3-input
// AND of one line from each group. The result is captured in a single output
// register, which gives exactly one clock of latency from sampling addr/en to
// the wordline update.
//
// Parameters:
//   WL_ACTIVE_LOW  1: selected wordline is driven 0 and the rest 1 (default).
//                  0: selected wordline is driven 1 and the rest 0.
//
// Optional feature macro: DEC_ADDR_PARITY_EN
//   When this macro is defined, the block adds:
//   - addr_par: even parity over addr.
//   - par_err: registered flag for a parity mismatch.
//   An enabled cycle with bad parity selects no row and raises par_err.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset, overrides all inputs
//   en        in   1   decode enable
//   addr      in   6   row address, bit 0 is the LSB
//   addr_par  in   1   even parity over addr   (DEC_ADDR_PARITY_EN only)
//   par_err   out  1   registered parity error (DEC_ADDR_PARITY_EN only)
//   wordline  out 64   registered wordlines, bit i selected when addr == i
//   wl_valid  out  1   registered, 1 when a row is currently selected
// -----------------------------------------------------------------------------
module dec_6_to_64 #(
   parameter bit WL_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [5:0]  addr,
`ifdef DEC_ADDR_PARITY_EN
   input  logic        addr_par,
   output logic        par_err,
`endif
   output logic [63:0] wordline,
   output logic        wl_valid
);

   // Value of wordline when no row is selected.
   localparam logic [63:0] WL_INACTIVE = {64{WL_ACTIVE_LOW}};

   logic [3:0]  pre_lo;   // one-hot decode of addr[1:0]
   logic [3:0]  pre_mid;  // one-hot decode of addr[3:2]
   logic [3:0]  pre_hi;   // one-hot decode of addr[5:4]
   logic [63:0] hot;      // active-high one-hot decode, before gating
   logic [63:0] hot_gated;
   logic        decode_ok;

   always_comb begin
      pre_lo  = 4'b0000;
      pre_mid = 4'b0000;
      pre_hi  = 4'b0000;
      pre_lo[addr[1:0]]  = 1'b1;
      pre_mid[addr[3:2]] = 1'b1;
      pre_hi[addr[5:4]]  = 1'b1;
   end

   // Wordline index i = 16*addr[5:4] + 4*addr[3:2] + addr[1:0].
   for (genvar i = 0; i < 64; i++) begin : g_and
      assign hot[i] = pre_hi[i / 16] & pre_mid[(i / 4) % 4] & pre_lo[i % 4];
   end

`ifdef DEC_ADDR_PARITY_EN
   logic par_bad;

   // Even parity: the XOR of addr and addr_par must be 0.
   assign par_bad   = ^{addr, addr_par};
   assign decode_ok = en & ~par_bad;
`else
   assign decode_ok = en;
`endif

   // A row is selected only when decoding is allowed.
   // Idle and error cycles select nothing; the previous row is not held.
   assign hot_gated = decode_ok ? hot : 64'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wordline <= WL_INACTIVE;
         wl_valid <= 1'b0;
      end else begin
         wordline <= WL_ACTIVE_LOW ? ~hot_gated : hot_gated;
         wl_valid <= decode_ok;
      end
   end

`ifdef DEC_ADDR_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par_err <= 1'b0;
      end else begin
         par_err <= en & par_bad;
      end
   end
`endif

endmodule

// File: tb/tb_dec_6_to_64.sv
// -----------------------------------------------------------------------------
// tb_dec_6_to_64 -- self-checking bench for dec_6_to_64.
//
// Two instances share the same inputs:
//   - dut_lo uses the default active-low polarity.
//   - dut_hi uses active-high polarity.
// Expected outputs come from a reference model that works directly on the row
// number. The selected bit is 1 << addr, and it is inverted for active-low.
// Inputs are applied 1 ns after a rising edge. Outputs are checked 1 ns after
// the next rising edge.
// -----------------------------------------------------------------------------
module tb_dec_6_to_64;

   logic        clk;
   logic        rst;
   logic        en;
   logic [5:0]  addr;
   logic [63:0] wordline_lo;
   logic [63:0] wordline_hi;
   logic        wl_valid_lo;
   logic        wl_valid_hi;
`ifdef DEC_ADDR_PARITY_EN
   logic        addr_par;
   logic        par_err_lo;
   logic        par_err_hi;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   dec_6_to_64 #(.WL_ACTIVE_LOW(1'b1)) dut_lo (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .addr     (addr),
`ifdef DEC_ADDR_PARITY_EN
      .addr_par (addr_par),
      .par_err  (par_err_lo),
`endif
      .wordline (wordline_lo),
      .wl_valid (wl_valid_lo)
   );

   dec_6_to_64 #(.WL_ACTIVE_LOW(1'b0)) dut_hi (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .addr     (addr),
`ifdef DEC_ADDR_PARITY_EN
      .addr_par (addr_par),
      .par_err  (par_err_hi),
`endif
      .wordline (wordline_hi),
      .wl_valid (wl_valid_hi)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [63:0] model_wl(input bit sel, input int row, input bit active_low);
      logic [63:0] one_hot;
      one_hot = sel ? (64'd1 << row) : 64'd0;
      return active_low ? ~one_hot : one_hot;
   endfunction

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Applies one cycle of inputs and checks the registered result.
   task automatic step(input bit r, input bit e, input int a, input bit bad_par);
      bit sel;
      rst  = r;
      en   = e;
      addr = a[5:0];
`ifdef DEC_ADDR_PARITY_EN
      addr_par = (^a[5:0]) ^ bad_par;
      sel      = !r && e && !bad_par;
`else
      sel      = !r && e;
`endif
      @(posedge clk);
      #1;
      chk("wordline_lo", wordline_lo, model_wl(sel, a, 1'b1));
      chk("wordline_hi", wordline_hi, model_wl(sel, a, 1'b0));
      chk("wl_valid_lo", {63'd0, wl_valid_lo}, {63'd0, sel});
      chk("wl_valid_hi", {63'd0, wl_valid_hi}, {63'd0, sel});
      // At most one row may be active, and one is active exactly when valid.
      chk("onehot_lo", 64'($countones(~wordline_lo)), sel ? 64'd1 : 64'd0);
`ifdef DEC_ADDR_PARITY_EN
      chk("par_err_lo", {63'd0, par_err_lo}, {63'd0, (!r && e && bad_par)});
      chk("par_err_hi", {63'd0, par_err_hi}, {63'd0, (!r && e && bad_par)});
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      addr = 6'd0;
`ifdef DEC_ADDR_PARITY_EN
      addr_par = 1'b0;
`endif
      @(posedge clk);
      #1;

      // Reset has priority over en and addr.
      step(1'b1, 1'b1, 5, 1'b0);
      step(1'b1, 1'b1, 5, 1'b0);
      chk("reset_lo_const", wordline_lo, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("reset_hi_const", wordline_hi, 64'h0000_0000_0000_0000);

      // Exhaustive sweep of all rows, back to back.
      for (int a = 0; a < 64; a++) begin
         step(1'b0, 1'b1, a, 1'b0);
         if (a == 0) begin
            chk("addr0_lo_const", wordline_lo, 64'hFFFF_FFFF_FFFF_FFFE);
            chk("addr0_hi_const", wordline_hi, 64'h0000_0000_0000_0001);
         end
         if (a == 63) begin
            chk("addr63_lo_const", wordline_lo, 64'h7FFF_FFFF_FFFF_FFFF);
            chk("addr63_hi_const", wordline_hi, 64'h8000_0000_0000_0000);
         end
      end

      // Enable gating: an idle cycle does not hold the previous row.
      step(1'b0, 1'b0, 37, 1'b0);
      step(1'b0, 1'b1, 37, 1'b0);
      chk("addr37_lo_const", wordline_lo, 64'hFFFF_FFDF_FFFF_FFFF);
      step(1'b0, 1'b0, 37, 1'b0);

      // Reset in the middle of decoding.
      step(1'b0, 1'b1, 12, 1'b0);
      step(1'b1, 1'b1, 12, 1'b0);
      step(1'b0, 1'b1, 12, 1'b0);

      // Random traffic, with occasional reset and idle cycles.
      for (int k = 0; k < 300; k++) begin
         step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 63)), 1'b0);
      end

`ifdef DEC_ADDR_PARITY_EN
      // Parity: correct parity decodes normally; bad parity selects no row.
      step(1'b0, 1'b1, 3, 1'b0);
      step(1'b0, 1'b1, 3, 1'b1);
      chk("par_bad_lo_const", wordline_lo, 64'hFFFF_FFFF_FFFF_FFFF);
      step(1'b0, 1'b0, 3, 1'b1);
      for (int k = 0; k < 100; k++) begin
         step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 63)), $urandom_range(0, 2) == 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
